// File: rtl/venus_pkg.sv
// Venus pipeline shared definitions: datapath widths, opcode encodings and
// the immediate sign-extension helper used by fetch, decode and execute.
package venus_pkg;

    localparam int unsigned WORD  = 32;
    localparam int unsigned ADDR  = 32;
    localparam int unsigned W_OPC = 6;
    localparam int unsigned W_OPR = 32;
    localparam int unsigned W_RD  = 4;
    localparam int unsigned W_IMM = 16;

    typedef enum logic [W_OPC-1:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_XOR  = 6'h05,
        OP_SLL  = 6'h07,
        OP_SRL  = 6'h08,
        OP_SRA  = 6'h09,
        OP_MOV  = 6'h0A,
        OP_LDI  = 6'h0B,
        OP_ADDI = 6'h0C,
        OP_MUL  = 6'h0D,
        OP_LD   = 6'h10,
        OP_ST   = 6'h11,
        OP_JMP  = 6'h18,
        OP_BZ   = 6'h19,
        OP_BNZ  = 6'h1A
    } opcode_e;

    function automatic logic [W_OPR-1:0] sign_extend(input logic [W_IMM-1:0] imm);
        return {{(W_OPR - W_IMM){imm[W_IMM-1]}}, imm};
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU / branch resolver for the Venus execute stage.
// Optional MUL (opcode 0x0D) is built only when EXEC_MUL_EN is defined.
module exec_alu
    import venus_pkg::*;
(
    input  logic [W_OPC-1:0] opcode,
    input  logic [W_OPR-1:0] opr0,
    input  logic [W_OPR-1:0] opr1,
    input  logic [W_OPR-1:0] sx,
    input  logic [ADDR-1:0]  pc,
    output logic [W_OPR-1:0] result,
    output logic             taken,
    output logic [ADDR-1:0]  addr
);

    logic [4:0]      sh;
    logic [ADDR-1:0] mem_addr;
    logic [ADDR-1:0] target;

    assign sh       = opr1[4:0];
    assign mem_addr = opr0 + sx;
    assign target   = pc + sx;

    always_comb begin
        result = '0;
        taken  = 1'b0;
        addr   = '0;
        case (opcode)
            OP_ADD:  result = opr0 + opr1;
            OP_SUB:  result = opr0 - opr1;
            OP_AND:  result = opr0 & opr1;
            OP_OR:   result = opr0 | opr1;
            OP_XOR:  result = opr0 ^ opr1;
            OP_SLL:  result = opr0 << sh;
            OP_SRL:  result = opr0 >> sh;
            OP_SRA:  result = $signed(opr0) >>> sh;
            OP_MOV:  result = opr1;
            OP_LDI:  result = sx;
            OP_ADDI: result = opr0 + sx;
`ifdef EXEC_MUL_EN
            OP_MUL:  result = opr0 * opr1;
`endif
            OP_LD,
            OP_ST:   addr = mem_addr;
            OP_JMP: begin
                taken = 1'b1;
                addr  = target;
            end
            OP_BZ: begin
                taken = (opr0 == '0);
                addr  = target;
            end
            OP_BNZ: begin
                taken = (opr0 != '0);
                addr  = target;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Venus execute stage: one-cycle registered ALU/load/branch output with
// stall hold and wrong-path squash. Define EXEC_MUL_EN to enable MUL.
module execute_stage
    import venus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [ADDR-1:0]  pc_i,
    input  logic [W_IMM-1:0] imm_i,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    output logic [ADDR-1:0]  ldst_addr_o,
    output logic             ldst_write_o,
    output logic [W_OPR-1:0] ldst_data_o,
    input  logic [W_OPR-1:0] ldst_data_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic             branch_o,
    output logic [ADDR-1:0]  branch_addr_o
);

    logic [W_OPR-1:0] sx;
    logic [W_OPR-1:0] alu_result;
    logic             alu_taken;
    logic [ADDR-1:0]  alu_addr;
    logic             is_ld;
    logic             is_st;
    logic             exec_v;

    logic             v_q;
    logic             wb_q;
    logic [W_RD-1:0]  wb_r_q;
    logic [W_OPR-1:0] result_q;
    logic             branch_q;
    logic [ADDR-1:0]  branch_addr_q;
    logic             ld_q;
    logic [ADDR-1:0]  ld_addr_q;

    assign sx     = sign_extend(imm_i);
    assign is_ld  = (opecode_i == OP_LD);
    assign is_st  = (opecode_i == OP_ST);
    // A redirect on the output marks the incoming instruction as wrong-path.
    assign exec_v = v_i & ~branch_q;

    exec_alu u_alu (
        .opcode (opecode_i),
        .opr0   (opr0_i),
        .opr1   (opr1_i),
        .sx     (sx),
        .pc     (pc_i),
        .result (alu_result),
        .taken  (alu_taken),
        .addr   (alu_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q           <= 1'b0;
            wb_q          <= 1'b0;
            wb_r_q        <= '0;
            result_q      <= '0;
            branch_q      <= 1'b0;
            branch_addr_q <= '0;
            ld_q          <= 1'b0;
            ld_addr_q     <= '0;
        end else if (!stall_i) begin
            v_q           <= exec_v;
            wb_q          <= wb_i;
            wb_r_q        <= wb_r_i;
            result_q      <= alu_result;
            branch_q      <= exec_v & alu_taken;
            branch_addr_q <= alu_addr;
            ld_q          <= exec_v & is_ld;
            ld_addr_q     <= alu_addr;
        end
    end

    // A stalled load re-presents its address so the synchronous memory keeps
    // returning the same word while the output is held.
    always_comb begin
        ldst_addr_o = '0;
        if (stall_i && v_q && ld_q) begin
            ldst_addr_o = ld_addr_q;
        end else if (is_ld || is_st) begin
            ldst_addr_o = alu_addr;
        end
    end

    assign ldst_write_o  = v_i & is_st & ~stall_i & ~branch_q;
    assign ldst_data_o   = opr1_i;
    assign stall_o       = stall_i;
    assign v_o           = v_q;
    assign wb_o          = v_q & wb_q;
    assign wb_r_o        = wb_r_q;
    assign result_o      = ld_q ? ldst_data_i : result_q;
    assign branch_o      = branch_q;
    assign branch_addr_o = branch_addr_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes reference-model
// expectations, a monitor pops and compares them every cycle.
module tb_execute_stage;
    import venus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i, stall_i, stall_o;
    logic [31:0] pc_i;
    logic [15:0] imm_i;
    logic [5:0]  opecode_i;
    logic [31:0] opr0_i, opr1_i;
    logic        wb_i;
    logic [3:0]  wb_r_i;
    logic [31:0] ldst_addr_o;
    logic        ldst_write_o;
    logic [31:0] ldst_data_o;
    logic [31:0] ldst_data_i;
    logic        v_o;
    logic [31:0] result_o;
    logic        wb_o;
    logic [3:0]  wb_r_o;
    logic        branch_o;
    logic [31:0] branch_addr_o;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk           (clk),
        .reset         (reset),
        .v_i           (v_i),
        .stall_i       (stall_i),
        .stall_o       (stall_o),
        .pc_i          (pc_i),
        .imm_i         (imm_i),
        .opecode_i     (opecode_i),
        .opr0_i        (opr0_i),
        .opr1_i        (opr1_i),
        .wb_i          (wb_i),
        .wb_r_i        (wb_r_i),
        .ldst_addr_o   (ldst_addr_o),
        .ldst_write_o  (ldst_write_o),
        .ldst_data_o   (ldst_data_o),
        .ldst_data_i   (ldst_data_i),
        .v_o           (v_o),
        .result_o      (result_o),
        .wb_o          (wb_o),
        .wb_r_o        (wb_r_o),
        .branch_o      (branch_o),
        .branch_addr_o (branch_addr_o)
    );

    // Synchronous data memory (1 KiB, word addressed), read data one cycle later.
    logic [31:0] dmem [0:255];
    logic [31:0] rdata;
    assign ldst_data_i = rdata;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
            rdata <= '0;
        end else begin
            if (ldst_write_o) dmem[ldst_addr_o[9:2]] <= ldst_data_o;
            rdata <= dmem[ldst_addr_o[9:2]];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic        v, wb, br;
        logic [31:0] res, baddr;
        logic [3:0]  wbr;
    } out_rec_t;

    typedef struct {
        int unsigned due;
        logic        wr, stall;
        logic [31:0] addr, data;
    } comb_rec_t;

    out_rec_t  out_q[$];
    comb_rec_t comb_q[$];
    logic      done = 1'b0;

    // Reference model state: what the output stage should be holding.
    logic        m_v, m_wb, m_br, m_ld;
    logic [31:0] m_res, m_baddr, m_ldaddr;
    logic [3:0]  m_wbr;
    logic [31:0] ref_mem [0:255];

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] s);
        logic [31:0] p;
        p = 32'd1 << b[4:0];
        case (op)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a & b;
            6'h04: return a | b;
            6'h05: return a ^ b;
            6'h07: return a * p;
            6'h08: return a / p;
            6'h09: return a[31] ? ((a / p) | ~(32'hFFFF_FFFF / p)) : (a / p);
            6'h0A: return b;
            6'h0B: return s;
            6'h0C: return a + s;
`ifdef EXEC_MUL_EN
            6'h0D: return a * b;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [5:0] op, input logic [31:0] a);
        return (op == 6'h18) || (op == 6'h19 && a == 0) || (op == 6'h1A && a != 0);
    endfunction

    function automatic logic [5:0] pick_op(input int unsigned k);
        case (k)
            0: return 6'h00;  1: return 6'h01;  2: return 6'h02;  3: return 6'h03;
            4: return 6'h04;  5: return 6'h05;  6: return 6'h07;  7: return 6'h08;
            8: return 6'h09;  9: return 6'h0A; 10: return 6'h0B; 11: return 6'h0C;
           12: return 6'h0D; 13: return 6'h10; 14: return 6'h11; 15: return 6'h18;
           16: return 6'h19; 17: return 6'h1A; 18: return 6'h06; 19: return 6'h1F;
           default: return 6'h3F;
        endcase
    endfunction

    task automatic model_clear();
        m_v = 0; m_wb = 0; m_br = 0; m_ld = 0;
        m_res = 0; m_baddr = 0; m_ldaddr = 0; m_wbr = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
    endtask

    task automatic step(input logic v, input logic st, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                        input logic [31:0] pc, input logic wb, input logic [3:0] wbr);
        logic [31:0] s, ea;
        logic        ex, is_mem;
        comb_rec_t   c;
        out_rec_t    o;
        @(posedge clk);
        #1;
        v_i = v; stall_i = st; opecode_i = op; opr0_i = a; opr1_i = b;
        imm_i = imm; pc_i = pc; wb_i = wb; wb_r_i = wbr;
        s      = {{16{imm[15]}}, imm};
        ea     = a + s;
        is_mem = (op == 6'h10) || (op == 6'h11);
        ex     = v && !m_br;
        c.due   = cyc;
        c.stall = st;
        c.data  = b;
        c.wr    = ex && (op == 6'h11) && !st;
        c.addr  = (st && m_v && m_ld) ? m_ldaddr : (is_mem ? ea : 32'h0);
        comb_q.push_back(c);
        if (!st) begin
            if (c.wr) ref_mem[ea[9:2]] = b;
            m_v      = ex;
            m_wb     = wb;
            m_wbr    = wbr;
            m_ld     = ex && (op == 6'h10);
            m_ldaddr = ea;
            m_res    = m_ld ? ref_mem[ea[9:2]] : ref_alu(op, a, b, s);
            m_br     = ex && ref_taken(op, a);
            m_baddr  = pc + s;
        end
        o.due = cyc + 1; o.v = m_v; o.wb = m_v && m_wb; o.br = m_br;
        o.res = m_res; o.baddr = m_baddr; o.wbr = m_wbr;
        out_q.push_back(o);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        v_i   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b1;
        stall_i = 1'b0;
    endtask

    // Stimulus
    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [15:0] imm;
        int          k;
        reset = 1'b1;
        v_i = 0; stall_i = 0; opecode_i = 0; opr0_i = 0; opr1_i = 0;
        imm_i = 0; pc_i = 0; wb_i = 0; wb_r_i = 0;
        model_clear();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        step(0, 0, 6'h01, 1, 2, 0, 0, 1, 4'd2);
        step(1, 0, 6'h01, 5, 7, 0, 0, 1, 4'd3);
        step(1, 0, 6'h11, 32'h10, 32'hDEADBEEF, 16'd4, 0, 0, 4'd0);
        step(1, 0, 6'h10, 32'h14, 0, 16'd0, 0, 1, 4'd5);
        repeat (3) step(1, 1, 6'h11, 32'h14, 32'h12345678, 16'd0, 0, 0, 4'd0);
        step(0, 0, 6'h00, 0, 0, 0, 0, 0, 4'd0);
        step(1, 0, 6'h10, 32'h14, 0, 16'd0, 0, 1, 4'd6);
        step(1, 0, 6'h19, 0, 0, 16'hFFF8, 32'h20, 0, 4'd0);
        step(1, 0, 6'h11, 32'h40, 32'hAAAA5555, 16'd0, 0, 0, 4'd0);
        step(1, 0, 6'h10, 32'h40, 0, 16'd0, 0, 1, 4'd7);
        step(1, 0, 6'h09, 32'h80000000, 4, 0, 0, 1, 4'd8);
        step(1, 0, 6'h0D, 6, 7, 0, 0, 1, 4'd9);
        step(1, 0, 6'h1A, 0, 0, 16'h0010, 32'h100, 1, 4'd1);
        step(1, 0, 6'h18, 0, 0, 16'h0040, 32'h200, 0, 4'd0);
        step(1, 1, 6'h01, 1, 1, 0, 0, 1, 4'd2);
        async_reset();
        step(0, 0, 6'h00, 0, 0, 0, 0, 0, 4'd0);

        for (int n = 0; n < 500; n++) begin
            op = pick_op($urandom_range(0, 20));
            if (op == 6'h10 || op == 6'h11) begin
                a   = 4 * $urandom_range(8, 200);
                k   = int'($urandom_range(0, 16)) - 8;
                imm = 16'(4 * k);
            end else begin
                a   = (op == 6'h19 || op == 6'h1A) && $urandom_range(0, 1) == 1 ? 32'h0 : $urandom;
                imm = 16'($urandom);
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, op, a, $urandom,
                 imm, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
        end
        step(0, 0, 6'h00, 0, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        #1 done = 1'b1;
    end

    // Monitor / scoreboard
    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    initial begin
        out_rec_t  o;
        comb_rec_t c;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_v_o", 32'(v_o), 0);
                chk("reset_wb_o", 32'(wb_o), 0);
                chk("reset_wb_r_o", 32'(wb_r_o), 0);
                chk("reset_result_o", result_o, 0);
                chk("reset_branch_o", 32'(branch_o), 0);
                chk("reset_branch_addr_o", branch_addr_o, 0);
                chk("reset_ldst_write_o", 32'(ldst_write_o), 0);
                out_q.delete();
                comb_q.delete();
            end else begin
                while (comb_q.size() > 0 && comb_q[0].due == cyc) begin
                    c = comb_q.pop_front();
                    chk("ldst_write_o", 32'(ldst_write_o), 32'(c.wr));
                    chk("ldst_addr_o", ldst_addr_o, c.addr);
                    chk("ldst_data_o", ldst_data_o, c.data);
                    chk("stall_o", 32'(stall_o), 32'(c.stall));
                end
                while (out_q.size() > 0 && out_q[0].due == cyc) begin
                    o = out_q.pop_front();
                    chk("v_o", 32'(v_o), 32'(o.v));
                    chk("wb_o", 32'(wb_o), 32'(o.wb));
                    chk("branch_o", 32'(branch_o), 32'(o.br));
                    if (o.v) begin
                        chk("result_o", result_o, o.res);
                        chk("wb_r_o", 32'(wb_r_o), 32'(o.wbr));
                    end
                    if (o.br) chk("branch_addr_o", branch_addr_o, o.baddr);
                end
            end
            if (done) break;
        end
        chk("scoreboard_leftover", 32'(out_q.size() + comb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the Venus in-order pipeline (the `execute_instruction` role). It takes one decoded instruction per cycle from decode and performs ALU operations, data-memory load/store and branch resolution. It presents a registered result and write-back request to the 16-entry register file, and a redirect to fetch and decode. It sits between decode, the synchronous data memory and the register file.

## Interface
- `WORD`, 32: instruction/data word width.
- `ADDR`, 32: instruction and data address width.
- `W_OPC`, 6: opcode width.
- `W_OPR`, 32: operand/result width.
- `W_RD`, 4: register index width (16 registers).
- `W_IMM`, 16: immediate width, sign-extended before use.

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `v_i` in 1: input instruction valid.
- `stall_i` in 1: downstream hold.
- `stall_o` out 1: hold request to decode.
- `pc_i` in ADDR: PC of the input instruction.
- `imm_i` in W_IMM: immediate.
- `opecode_i` in W_OPC: opcode.
- `opr0_i`, `opr1_i` in W_OPR: source operands.
- `wb_i` in 1: instruction writes a register.
- `wb_r_i` in W_RD: destination register index.
- `ldst_addr_o` out ADDR: data-memory address.
- `ldst_write_o` out 1: data-memory write strobe.
- `ldst_data_o` out W_OPR: store data.
- `ldst_data_i` in W_OPR: data-memory read data, valid one cycle after the address is presented.
- `v_o` out 1: output valid.
- `result_o` out W_OPR: write-back value.
- `wb_o` out 1: write-back enable.
- `wb_r_o` out W_RD: write-back register index.
- `branch_o` out 1: redirect taken.
- `branch_addr_o` out ADDR: redirect target.

## Operation
- Let `sx` = sign-extended `imm_i`.
- Let `sh` = `opr1_i[4:0]`.
- Opcodes:
  - NOP 0x00: result 0.
  - ADD 0x01: result `opr0+opr1`.
  - SUB 0x02: result `opr0-opr1`.
  - AND 0x03, OR 0x04, XOR 0x05: bitwise result.
  - SLL 0x07, SRL 0x08: logical shift of `opr0` by `sh`.
  - SRA 0x09: arithmetic right shift of `opr0` by `sh`.
  - MOV 0x0A: result `opr1`.
  - LDI 0x0B: result `sx`.
  - ADDI 0x0C: result `opr0+sx`.
  - LD 0x10: result is memory data at `opr0+sx`.
  - ST 0x11: writes `opr1` to `opr0+sx`.
  - JMP 0x18: branch taken.
  - BZ 0x19: branch taken if `opr0==0`.
  - BNZ 0x1A: branch taken if `opr0!=0`.
- Branch target is `pc_i+sx`.
- Any other opcode executes as NOP.
- All arithmetic is modulo 2^W_OPR; there are no flags.
- Address generation:
  - `ldst_addr_o` = `opr0_i+sx` (truncated to ADDR), driven combinationally whenever the input is LD or ST.
  - Otherwise `ldst_addr_o` = 0.
  - Exception: when `stall_i` is high and the output holds a valid LD, `ldst_addr_o` is driven from the registered load address instead.
- Store: `ldst_write_o` = `v_i` & ST & `!stall_i` & `!branch_o`; `ldst_data_o` = `opr1_i`.
- Load: the output stage keeps a load flag. While it is set, `result_o` = `ldst_data_i`; otherwise `result_o` = the registered ALU result.
- `wb_o` = `v_o` & registered `wb_i`. ST and branch instructions keep whatever `wb_i` decode supplied.
- Squash: while `branch_o` is high, the instruction presented on `v_i` is wrong-path. It must not execute, store or branch, and next-cycle `v_o` is 0.
- An instruction with `v_i`=0 produces `v_o`=0, `wb_o`=0 and `branch_o`=0 in its output cycle.

## Timing
- Reset: every output register clears to 0, so `v_o`, `wb_o`, `wb_r_o`, `result_o`, `branch_o` and `branch_addr_o` are 0. `ldst_write_o` is 0 until the first valid ST.
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs from edge N until edge N+1.
- `branch_o` is registered and is high for exactly one cycle per taken branch, together with that branch's `v_o`.
- Hold: `stall_o` = `stall_i`. While `stall_i` is high:
  - output registers keep their values;
  - no store is issued;
  - a held load keeps returning the same data through the address hold described in Operation.
- `branch_o` is held with the other output registers; fetch and decode must tolerate a repeated redirect.
- An asynchronous reset during a stall or a branch clears all state immediately.

## Configuration
- `EXEC_MUL_EN`:
  - When defined, adds opcode MUL 0x0D with result = low W_OPR bits of `opr0*opr1`, single cycle.
  - When undefined, 0x0D executes as NOP and no multiplier is synthesized.

## Structure
- Shared package `venus_pkg`: width parameters (WORD, ADDR, W_OPC, W_OPR, W_RD, W_IMM) and all opcode constants. Fetch, decode and execute all use it.
- One sub-module, `exec_alu`: purely combinational. Its inputs are opcode, operands and `sx`; its outputs are the result, branch-taken and the branch/load-store address.
- The pipeline register and the load, hold and squash logic stay in `execute_stage`.

## Test plan
- ADD: `opr0`=5, `opr1`=7, `wb_i`=1, `wb_r_i`=3, `v_i`=1 → next cycle `v_o`=1, `result_o`=0xC, `wb_o`=1, `wb_r_o`=3.
- Reset held low → all outputs 0. Release reset with `v_i`=0 → `v_o` and `wb_o` stay 0.
- Store then load:
  - ST with `opr0`=0x10, `imm`=4, `opr1`=0xDEADBEEF → `ldst_write_o`=1 at address 0x14.
  - Next, LD with `opr0`=0x14, `imm`=0 → following cycle `result_o`=0xDEADBEEF.
- BZ with `opr0`=0, `pc`=0x20, `imm`=0xFFF8 → `branch_o`=1 and `branch_addr_o`=0x18 for one cycle. The following `v_i`=1 ST is squashed: no write, and `v_o`=0 in the next cycle.
- `stall_i` high for 3 cycles while a LD is at the output → `result_o`, `v_o`, `wb_r_o` stable and `stall_o`=1 throughout. An ST presented on the input during the stall is not written.
- SRA: `opr0`=0x80000000, `opr1`=4 → `result_o`=0xF8000000. With `EXEC_MUL_EN`: MUL 6×7 → `result_o`=0x2A.
